// File: rtl/dii_package.sv
// Debug-interconnect flit type shared by every debug-stream producer and consumer.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/ncm_arb_pkg.sv
// Shared types and helpers for the NoC control module packet arbiter.
package ncm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        DISCARD = 2'd2
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) even for tiny source counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ncm_rr_pick.sv
// Combinational winner selection: lowest-index priority request, else the
// first non-priority request after rr_ptr with wrap-around.
module ncm_rr_pick
    import ncm_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDW     = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] prio_mask,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    logic [NUM_SRC-1:0] hi;
    logic [NUM_SRC-1:0] lo;
    logic [IDW-1:0]     j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        hi    = req & prio_mask;
        lo    = req & ~prio_mask;
        // Loops run from the least preferred candidate up so the preferred one is assigned last.
        if (|hi) begin
            found = 1'b1;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                j = IDW'(NUM_SRC - 1 - k);
                if (hi[j]) idx = j;
            end
        end else begin
            for (int unsigned k = NUM_SRC; k > 0; k--) begin
                j = IDW'((32'(rr_ptr) + k) % NUM_SRC);
                if (lo[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
    end

endmodule

// File: rtl/ncm_pkt_arbiter.sv
// Packet arbiter feeding the NoC-to-debug CDC FIFO: strict priority plus
// round-robin, no interleaving, over-length packets truncated and drained.
module ncm_pkt_arbiter
    import dii_package::*;
    import ncm_arb_pkg::*;
#(
    parameter int unsigned          NUM_SRC     = 4,
    parameter logic [NUM_SRC-1:0]   PRIO_MASK   = 4'b0001,
    parameter int unsigned          MAX_PKT_LEN = 12,
    parameter int unsigned          IDW         = clog2_min1(NUM_SRC)
) (
    input  logic               clk_noc,
    input  logic               rst_noc_n,
    input  dii_flit            in_flit [NUM_SRC],
    output logic [NUM_SRC-1:0] in_ready,
    output dii_flit            out_flit,
    input  logic               out_ready,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic [7:0]         trunc_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(MAX_PKT_LEN - 1);

    arb_state_e         state;
    logic [7:0]         flit_cnt;
    logic [IDW-1:0]     rr_ptr;

    dii_flit            cur;
    logic [NUM_SRC-1:0] vld;
    logic [NUM_SRC-1:0] pick_req;
    logic [IDW-1:0]     pick_ptr;
    logic [IDW-1:0]     ptr_eop;
    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic               xfer;
    logic               at_limit;

    always_comb begin
        vld = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) vld[i] = in_flit[i].valid;
        cur      = in_flit[grant_id];
        xfer     = (state == PASS) && cur.valid && out_ready;
        at_limit = (flit_cnt == LAST_IDX);
        ptr_eop  = PRIO_MASK[grant_id] ? rr_ptr : grant_id;
        // One picker serves both IDLE and end-of-packet; the finishing source is masked out.
        if (state == IDLE) begin
            pick_req = vld;
            pick_ptr = rr_ptr;
        end else begin
            pick_req = vld & ~(NUM_SRC'(1) << grant_id);
            pick_ptr = ptr_eop;
        end
    end

    ncm_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_pick (
        .req       (pick_req),
        .prio_mask (PRIO_MASK),
        .rr_ptr    (pick_ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    always_comb begin
        out_flit = '0;
        in_ready = '0;
        case (state)
            PASS: begin
                out_flit = cur;
                if (at_limit) out_flit.last = 1'b1;
                in_ready[grant_id] = out_ready;
            end
            DISCARD: in_ready[grant_id] = 1'b1;
            default: ;
        endcase
    end

    assign grant_valid = (state != IDLE);

    always_ff @(posedge clk_noc or negedge rst_noc_n) begin
        if (!rst_noc_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            flit_cnt  <= '0;
            trunc_cnt <= '0;
            rr_ptr    <= IDW'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        flit_cnt <= '0;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (xfer) begin
                        if (!cur.last && at_limit) begin
                            if (trunc_cnt != 8'hFF) trunc_cnt <= trunc_cnt + 8'd1;
                            flit_cnt <= flit_cnt + 8'd1;
                            state    <= DISCARD;
                        end else if (cur.last) begin
                            rr_ptr   <= ptr_eop;
                            flit_cnt <= '0;
                            if (pick_found) grant_id <= pick_idx;
                            else            state    <= IDLE;
                        end else begin
                            flit_cnt <= flit_cnt + 8'd1;
                        end
                    end
                end
                DISCARD: begin
                    if (cur.valid && cur.last) begin
                        rr_ptr <= ptr_eop;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ncm_pkt_arbiter.sv
// Directed bench for ncm_pkt_arbiter: per-source packet generators and a
// log of accepted output flits compared against hand-built expectations.
module tb_ncm_pkt_arbiter;
    import dii_package::*;

    localparam int NS = 4;

    logic          clk_noc = 1'b0;
    logic          rst_noc_n = 1'b0;
    dii_flit       in_flit [NS];
    logic [NS-1:0] in_ready;
    dii_flit       out_flit;
    logic          out_ready;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic [7:0]    trunc_cnt;

    ncm_pkt_arbiter #(
        .NUM_SRC     (4),
        .PRIO_MASK   (4'b0001),
        .MAX_PKT_LEN (12)
    ) dut (
        .clk_noc     (clk_noc),
        .rst_noc_n   (rst_noc_n),
        .in_flit     (in_flit),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .trunc_cnt   (trunc_cnt)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        int          cyc;
        int          gid;
        logic [15:0] data;
        logic        last;
    } ent_t;

    ent_t       log_q[$];
    ent_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         c0;
    logic [3:0] rdy_pat = 4'b1111;
    int         src_npkt[NS];
    int         src_plen[NS];
    int         src_pkt[NS];
    int         src_flit[NS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fdata(input int s, input int p, input int f);
        return {s[3:0], p[3:0], f[7:0]};
    endfunction

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            in_flit[s] = '0;
            if (src_pkt[s] < src_npkt[s]) begin
                in_flit[s].valid = 1'b1;
                in_flit[s].last  = (src_flit[s] == src_plen[s] - 1);
                in_flit[s].data  = fdata(s, src_pkt[s], src_flit[s]);
            end
        end
        out_ready = rdy_pat[cyc % 4];
    endtask

    task automatic load(input int s, input int npkt, input int plen);
        src_npkt[s] = npkt;
        src_plen[s] = plen;
        src_pkt[s]  = 0;
        src_flit[s] = 0;
        drive();
    endtask

    task automatic clear_srcs();
        for (int s = 0; s < NS; s++) load(s, 0, 1);
    endtask

    // Sample at the falling edge, then advance sources that handshook at the rising edge.
    task automatic step(input int n);
        logic [NS-1:0] acc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_noc);
            for (int s = 0; s < NS; s++) acc[s] = in_flit[s].valid & in_ready[s];
            if (out_flit.valid && out_ready)
                log_q.push_back('{cyc, int'(grant_id), out_flit.data, out_flit.last});
            @(posedge clk_noc);
            #1;
            cyc++;
            for (int s = 0; s < NS; s++) begin
                if (acc[s]) begin
                    if (src_flit[s] == src_plen[s] - 1) begin
                        src_flit[s] = 0;
                        src_pkt[s]++;
                    end else begin
                        src_flit[s]++;
                    end
                end
            end
            drive();
        end
    endtask

    task automatic do_reset();
        rst_noc_n = 1'b0;
        clear_srcs();
        log_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk_noc);
        #1;
        rst_noc_n = 1'b1;
    endtask

    task automatic expect_ent(input int gid, input int p, input int f, input logic last);
        exp_q.push_back('{0, gid, fdata(gid, p, f), last});
    endtask

    task automatic verify(input string tag, input int base, input bit chk_cyc);
        check({tag, ".len"}, log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            check($sformatf("%s.gid%0d", tag, k), log_q[k].gid, exp_q[k].gid);
            check($sformatf("%s.data%0d", tag, k), {16'h0, log_q[k].data}, {16'h0, exp_q[k].data});
            check($sformatf("%s.last%0d", tag, k), {31'h0, log_q[k].last}, {31'h0, exp_q[k].last});
            if (chk_cyc) check($sformatf("%s.cyc%0d", tag, k), log_q[k].cyc, base + 1 + k);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int eg[8];

        // Reset state
        clear_srcs();
        #3;
        check("rst.out_flit", {14'h0, out_flit}, 32'h0);
        check("rst.in_ready", {28'h0, in_ready}, 32'h0);
        check("rst.grant_valid", {31'h0, grant_valid}, 32'h0);
        check("rst.trunc_cnt", {24'h0, trunc_cnt}, 32'h0);
        @(posedge clk_noc);
        #1;
        rst_noc_n = 1'b1;
        step(3);
        check("idle.grant_valid", {31'h0, grant_valid}, 32'h0);
        check("idle.nolog", log_q.size(), 0);

        // 3-flit packet on src2, first flit one cycle after valid rises
        load(2, 1, 3);
        c0 = cyc;
        step(6);
        for (int k = 0; k < 3; k++) expect_ent(2, 0, k, k == 2);
        verify("single", c0, 1'b1);

        // Round-robin between src1 and src3, back-to-back
        do_reset();
        load(1, 2, 2);
        load(3, 2, 2);
        c0 = cyc;
        step(12);
        eg = '{1, 1, 3, 3, 1, 1, 3, 3};
        for (int k = 0; k < 8; k++) expect_ent(eg[k], k / 4, k % 2, k % 2 == 1);
        verify("rr", c0, 1'b1);

        // Priority src0 arrives mid-packet of src2, beats waiting src3
        do_reset();
        load(2, 1, 4);
        load(3, 1, 2);
        c0 = cyc;
        step(2);
        load(0, 1, 2);
        step(10);
        for (int k = 0; k < 4; k++) expect_ent(2, 0, k, k == 3);
        for (int k = 0; k < 2; k++) expect_ent(0, 0, k, k == 1);
        for (int k = 0; k < 2; k++) expect_ent(3, 0, k, k == 1);
        verify("prio", c0, 1'b1);

        // 15-flit packet truncated to 12, remainder drained
        do_reset();
        load(1, 1, 15);
        c0 = cyc;
        step(25);
        for (int k = 0; k < 12; k++) expect_ent(1, 0, k, k == 11);
        verify("trunc", c0, 1'b1);
        check("trunc.drained", src_pkt[1], 1);
        check("trunc.cnt", {24'h0, trunc_cnt}, 32'd1);
        check("trunc.idle", {31'h0, grant_valid}, 32'h0);

        // Stalls with out_ready toggling 1010
        do_reset();
        rdy_pat = 4'b0101;
        load(1, 1, 4);
        c0 = cyc;
        step(14);
        for (int k = 0; k < 4; k++) expect_ent(1, 0, k, k == 3);
        verify("stall", c0, 1'b0);
        check("stall.drained", src_pkt[1], 1);
        rdy_pat = 4'b1111;
        drive();

        // Reset mid-packet, then round-robin restarts at source 0
        do_reset();
        load(2, 1, 1);
        step(3);
        load(3, 1, 5);
        step(3);
        check("mid.busy", {31'h0, grant_valid}, 32'h1);
        #2;
        rst_noc_n = 1'b0;
        #1;
        check("mid.out_flit", {14'h0, out_flit}, 32'h0);
        check("mid.in_ready", {28'h0, in_ready}, 32'h0);
        check("mid.grant_valid", {31'h0, grant_valid}, 32'h0);
        check("mid.grant_id", {30'h0, grant_id}, 32'h0);
        clear_srcs();
        log_q.delete();
        @(posedge clk_noc);
        #1;
        rst_noc_n = 1'b1;
        load(1, 1, 1);
        load(2, 1, 1);
        load(3, 1, 1);
        c0 = cyc;
        step(6);
        expect_ent(1, 0, 0, 1'b1);
        expect_ent(2, 0, 0, 1'b1);
        expect_ent(3, 0, 0, 1'b1);
        verify("restart", c0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
